// File: rtl/thirty_two_bit_xor_descrambler_pkg.sv
// ---------------------------------------------------------------------------
// thirty_two_bit_xor_descrambler_pkg
//
// Shared definitions for the XOR scrambler/descrambler pair. Both ends import
// this package so that they agree on the keystream polynomial, the default
// seed and the control state encoding.
//
// Contents:
//   LFSR_WIDTH    - keystream register width (32)
//   DEFAULT_POLY  - Galois feedback mask for x^32+x^22+x^2+x+1
//   DEFAULT_SEED  - seed used in place of an all-zero seed
//   state_e       - control state encoding (IDLE / RUN)
// ---------------------------------------------------------------------------
package thirty_two_bit_xor_descrambler_pkg;

  localparam int          LFSR_WIDTH   = 32;
  localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/thirty_two_bit_xor_descrambler_lfsr32_step.sv
// ---------------------------------------------------------------------------
// lfsr32_step
//
// Combinational next-state function of the 32-bit Galois LFSR. The same
// module sits in the transmitter, so both ends step the keystream
// identically.
//
// Ports:
//   state_i  in  32  current LFSR value
//   next_o   out 32  value after one keystream step
// ---------------------------------------------------------------------------
module lfsr32_step
  import thirty_two_bit_xor_descrambler_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] POLY = DEFAULT_POLY
) (
  input  logic [LFSR_WIDTH-1:0] state_i,
  output logic [LFSR_WIDTH-1:0] next_o
);

  // Galois form: shift right, and when the bit shifted out was a one, fold
  // the feedback mask into the whole register at once.
  assign next_o = {1'b0, state_i[LFSR_WIDTH-1:1]} ^ (state_i[0] ? POLY : '0);

endmodule

// File: rtl/thirty_two_bit_xor_descrambler.sv
// ---------------------------------------------------------------------------
// thirty_two_bit_xor_descrambler
//
// Recovers plaintext words from a stream scrambled by XOR with a Galois LFSR
// keystream. The keystream advances exactly once per accepted word so the
// block stays in lock-step with the transmitter.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   seed_load   in   1   load seed and enter RUN (zero seed -> DEF_SEED)
//   seed        in   32  keystream seed
//   in_valid    in   1   scrambled word present
//   in_ready    out  1   word accepted this cycle if in_valid
//   in_data     in   32  scrambled word
//   out_valid   out  1   descrambled word held in output register
//   out_ready   in   1   consumer takes out_data this cycle
//   out_data    out  32  descrambled word
//   word_count  out  16  words accepted since last seed load (wraps)
// ---------------------------------------------------------------------------
module thirty_two_bit_xor_descrambler
  import thirty_two_bit_xor_descrambler_pkg::*;
#(
  parameter int          WIDTH    = LFSR_WIDTH,
  parameter logic [31:0] POLY     = DEFAULT_POLY,
  parameter logic [31:0] DEF_SEED = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      word_count
);

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] word_count_q, word_count_d;

  logic [31:0] lfsr_next;
  logic [31:0] plain_word;
  logic        accept;

  lfsr32_step #(
    .POLY (POLY)
  ) u_lfsr_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_next)
  );

  // The data combine is the plain 32-bit XOR of the ALU path: scrambled word
  // against the keystream value that was current when the word arrived.
  assign plain_word = in_data ^ lfsr_q;

  // Ready only depends on state, the output register and the consumer; it
  // deliberately ignores in_valid so no valid->ready loop can form. The
  // seed_load cycle never accepts, so a reseed cannot race a data word.
  assign in_ready = (state_q == RUN) && !seed_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state logic. A reseed restarts the keystream and the counter but
  // leaves the output register alone so a held word still drains. The
  // keystream and counter only move on an accept; every stall freezes them.
  // When a word is accepted while the old one drains, the new word simply
  // overwrites it and out_valid stays high.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    word_count_d = word_count_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;

    if (seed_load) begin
      state_d      = RUN;
      lfsr_d       = (seed == 32'h0) ? DEF_SEED : seed;
      word_count_d = 16'h0;
    end else if (accept) begin
      lfsr_d       = lfsr_next;
      word_count_d = word_count_q + 16'h1;
    end

    if (accept) begin
      out_data_d  = plain_word;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // All state in one register bank. Reset drops any held word at once and
  // parks the block in IDLE until the next seed_load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= DEF_SEED;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_thirty_two_bit_xor_descrambler.sv
// ---------------------------------------------------------------------------
// tb_thirty_two_bit_xor_descrambler
//
// Drives the descrambler with directed and random traffic. A reference model
// of the keystream, handshake and counter predicts each descrambled word and
// pushes it into a queue; an independent monitor pops and compares whenever
// the consumer takes a word.
// ---------------------------------------------------------------------------
module tb_thirty_two_bit_xor_descrambler;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [31:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] word_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] expQ[$];
  logic [31:0] modelLfsr  = 32'h1;
  logic        modelRun   = 1'b0;
  logic        modelValid = 1'b0;
  logic [15:0] modelCount = 16'h0;

  thirty_two_bit_xor_descrambler dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // One keystream step written straight from the polynomial rule.
  function automatic logic [31:0] stepLfsr(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, predict the handshake for the coming edge and
  // update the model state the way the coming edge should.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy,
                               input logic sl, input logic [31:0] sd);
    logic expReady;
    logic acc;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    seed_load = sl;
    seed      = sd;
    #1;
    expReady = modelRun && !sl && (!modelValid || ordy);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
    acc = v && expReady;
    if (sl) begin
      modelRun   = 1'b1;
      modelLfsr  = (sd == 32'h0) ? 32'h1 : sd;
      modelCount = 16'h0;
    end else if (acc) begin
      expQ.push_back(d ^ modelLfsr);
      modelLfsr  = stepLfsr(modelLfsr);
      modelCount = modelCount + 16'h1;
    end
    if (acc) modelValid = 1'b1;
    else if (ordy && modelValid) modelValid = 1'b0;
  endtask

  // Monitor: whenever the consumer takes a word, compare with the oldest
  // predicted word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word: got 0x%08h expected no word", out_data);
        end else begin
          checkOutput("out_data", out_data, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    seed_load = 1'b0;
    seed      = 32'h0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset_out_data", out_data, 32'h0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("reset_word_count", {16'b0, word_count}, 32'h0);
    rst = 1'b0;

    // No seed yet: traffic is refused.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 32'h0);
      checkOutput("idle_out_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("idle_word_count", {16'b0, word_count}, 32'h0);
    end

    // Seed 1 and the known three-word stream.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1);
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    checkOutput("vec0", out_data, 32'h0000_0001);
    applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    checkOutput("vec1", out_data, 32'h7FDF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("vec2", out_data, 32'hD204_567A);
    checkOutput("vec_count", {16'b0, word_count}, 32'h3);

    // Zero seed behaves like seed 1.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("zero_seed", out_data, 32'h0000_0001);

    // Backpressure holds the word and freezes the keystream.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_out_data", out_data, 32'h0000_0001);
      checkOutput("stall_out_valid", {31'b0, out_valid}, 32'h1);
    end
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("resume", out_data, 32'h7FDF_FFFC);

    // Reseed while a word is held.
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h1);
    checkOutput("reseed_held_valid", {31'b0, out_valid}, 32'h1);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("reseed_first", out_data, 32'h0000_0001);
    checkOutput("reseed_count", {16'b0, word_count}, 32'h1);

    // Asynchronous reset between edges with a word held.
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("async_rst_data", out_data, 32'h0);
    checkOutput("async_rst_count", {16'b0, word_count}, 32'h0);
    expQ.delete();
    modelRun   = 1'b0;
    modelValid = 1'b0;
    modelCount = 16'h0;
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 32'h0);
    checkOutput("post_rst_idle_valid", {31'b0, out_valid}, 32'h0);

    // Counter wrap after 65536 accepts.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1);
    for (int i = 0; i < 65536; i++) applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_count", {16'b0, word_count}, 32'h0);

    // Random traffic with random stalls and reseeds.
    for (int i = 0; i < 3000; i++) begin
      logic sl;
      logic [31:0] sd;
      sl = ($urandom_range(0, 49) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, sl, sd);
    end
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("random_count", {16'b0, word_count}, {16'b0, modelCount});
    checkOutput("queue_empty", expQ.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thirty_two_bit_xor_descrambler.md
# thirty_two_bit_xor_descrambler

Receive-side counterpart of the XOR scrambling path: recovers plaintext 32-bit words from a stream scrambled by XOR with a Galois LFSR keystream. Sits after the ALU datapath's word stream input, with valid/ready handshakes on both sides. Holds keystream state, a one-entry output register and a word counter. Must stay in lock-step with the transmitter: one keystream step per word accepted.

## Interface
- WIDTH, 32, data and LFSR width; only 32 is supported.
- POLY, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).
- DEF_SEED, 32'h0000_0001, seed substituted when a zero seed is loaded.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- seed_load  input  1  loads `seed` into the LFSR and enters RUN.
- seed  input  32  keystream seed.
- in_valid  input  1  scrambled word present.
- in_ready  output  1  block accepts `in_data` this cycle.
- in_data  input  32  scrambled word.
- out_valid  output  1  descrambled word held in the output register.
- out_ready  input  1  consumer takes `out_data` this cycle.
- out_data  output  32  descrambled word.
- word_count  output  16  words accepted since the last seed load; wraps.

## Operation
- States:
  - IDLE: after reset, no seed; `in_ready`=0.
  - RUN: keystream valid.
- IDLE→RUN on `seed_load`. RUN→RUN on `seed_load` (reseed). Only `rst` returns to IDLE.
- Seeding:
  - seed==0 loads DEF_SEED instead, which prevents LFSR lock-up.
  - `word_count` clears on load.
- Accept condition: in_valid && in_ready, where in_ready = RUN && !seed_load && (!out_valid || out_ready).
- On accept:
  - out_data ← in_data ^ lfsr, using the current LFSR value.
  - out_valid ← 1.
  - lfsr ← (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
  - word_count ← word_count+1, modulo 2^16.
- Output register:
  - out_valid clears when out_ready && out_valid with no accept in the same cycle.
  - Accept and drain in the same cycle: out_valid stays 1 and the new word replaces the old.
- `seed_load` while out_valid=1: the held word is kept and drains normally. No word is accepted in the seed_load cycle.
- The LFSR never advances without an accept. Stalls (in_valid=0 or out_ready=0) freeze the keystream.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=0, word_count=0, lfsr=DEF_SEED, state=IDLE.
- Latency: 1 cycle. A word accepted at edge N appears on out_data/out_valid after edge N.
- Throughput: 1 word/cycle while out_ready stays high.
- in_ready is combinational from state, out_valid, out_ready and seed_load. There is no combinational path from in_valid to in_ready.
- out_data and out_valid are registered. out_data is stable while out_valid && !out_ready.
- Reset asserted mid-stream:
  - The held word is discarded and outputs return to reset values immediately, asynchronously.
  - The block stays in IDLE until the next seed_load.
- First accept is possible in the cycle after the seed_load cycle.

## Structure
- Shared package/header:
  - LFSR width.
  - POLY and DEF_SEED defaults.
  - State encodings (IDLE=1'b0, RUN=1'b1).
  - The scrambler uses the same header so both ends agree on the polynomial.
- Sub-module `lfsr32_step`: combinational next-state function (input state, POLY), shared with the transmitter.
- The data combine reuses the existing 32-bit XOR ALU component. The top level holds the FSM, LFSR register, output register and counter.

## Test plan
- Reset, no seed; in_valid=1 for 5 cycles → in_ready=0, out_valid=0, word_count=0 throughout.
- seed=1; stream 0x00000000, 0xFFFFFFFF, 0x12345678 with out_ready=1 → outputs 0x00000001, 0x7FDFFFFC, 0xD204567A on consecutive cycles; word_count=3.
- seed=0 → behaviour identical to seed=1 (DEF_SEED); first input 0x0 → output 0x00000001.
- Backpressure: out_ready=0 for 4 cycles after the first word → out_data held constant, in_ready=0, no LFSR advance; resuming still produces 0x7FDFFFFC for 0xFFFFFFFF.
- Reseed with seed=1 mid-stream while a word is held → held word drains unchanged; next input 0x0 → 0x00000001; word_count restarts at 1.
- Async rst pulse between clock edges while out_valid=1 → out_valid=0 immediately; 65536 accepts after reseed → word_count wraps to 0.
